pc_fetch_stage: RTL and testbench
=================================

Name: pc_fetch_stage

Overview:
- Parametrised program-counter and instruction-fetch stage for the pipelined RV32 CPU.
- Replaces the bare PC register in the CPU top.
- Owns the PC, drives the instruction-memory read handshake (busywait style) and loads the IF/ID pipeline register.
- Honours hazard-unit stalls and EX-stage redirects (branch/jump), including a redirect that arrives while a fetch is still outstanding.

Parameters:
XLEN, 32, width of PC and all addresses.
ILEN, 32, instruction width.
RESET_VECTOR, 0, PC value loaded on reset.
PC_STEP, 4, byte increment per sequential fetch.

Ports:
CLK  in  1  clock, all state updates on rising edge.
RESET  in  1  synchronous, active-high reset.
STALL  in  1  hazard unit: hold PC and IF/ID contents.
REDIRECT  in  1  EX stage: branch taken / jump; load REDIRECT_TARGET.
REDIRECT_TARGET  in  XLEN  redirect destination address.
IMEM_BUSYWAIT  in  1  instruction memory not ready; IMEM_INSTR is valid in a cycle where IMEM_READ=1 and IMEM_BUSYWAIT=0.
IMEM_INSTR  in  ILEN  instruction data from memory.
IMEM_READ  out  1  fetch request.
IMEM_ADDR  out  XLEN  fetch address (= PC).
PC  out  XLEN  current fetch PC.
IFID_PC  out  XLEN  PC of instruction held in IF/ID.
IFID_PC_NEXT  out  XLEN  IFID_PC + PC_STEP (feeds JAL/JALR link value).
IFID_INSTR  out  ILEN  instruction held in IF/ID.
IFID_VALID  out  1  IF/ID holds a live instruction (0 = bubble).
ADDR_MISALIGNED  out  1  one-cycle pulse: accepted redirect target not PC_STEP-aligned.

Behaviour:
- Reset is synchronous, active-high: at a rising edge with RESET=1, all state is reset.
  - Reset values: PC=RESET_VECTOR; IFID_PC=0; IFID_PC_NEXT=0; IFID_INSTR=0; IFID_VALID=0; ADDR_MISALIGNED=0; pending target=0; state=RUN.
  - RESET has priority over every other input.
  - RESET asserted mid-fetch abandons the fetch; the memory response is ignored.
- IMEM_ADDR=PC combinationally. IMEM_READ=1 in every state while RESET=0.
- Fetch complete ("done") = IMEM_READ & ~IMEM_BUSYWAIT.
- State RUN, evaluated in this priority order:
  1. REDIRECT=1 and done: PC<=REDIRECT_TARGET with low log2(PC_STEP) bits cleared; IFID_VALID<=0; returned instruction discarded; stay RUN.
  2. REDIRECT=1 and not done: latch the aligned target into the pending register; go to DRAIN; PC unchanged; IFID_VALID<=0.
  3. STALL=1: PC and all IFID_* hold; any returned instruction is discarded and refetched after STALL drops.
  4. done: IFID_PC<=PC; IFID_PC_NEXT<=PC+PC_STEP; IFID_INSTR<=IMEM_INSTR; IFID_VALID<=1; PC<=PC+PC_STEP.
  5. Otherwise (busy, no stall): PC holds; IFID_VALID<=0 so ID sees a bubble, not a duplicate.
- A redirect always beats STALL. The branch is resolved in EX, and the ID instruction is being flushed anyway.
- State DRAIN (waiting out the stale fetch; memory address must not change mid-access):
  - PC and IMEM_ADDR hold the old PC; IFID_VALID=0 every cycle.
  - done: discard data; PC<=pending target; go to RUN.
  - A further REDIRECT in DRAIN overwrites the pending target (newest wins). If it coincides with done, the newest target is loaded.
  - STALL is ignored in DRAIN.
- ADDR_MISALIGNED pulses high for one cycle in the cycle after any redirect is accepted (RUN or DRAIN) whose target has nonzero low log2(PC_STEP) bits. Execution continues at the aligned address.
- Arithmetic: PC+PC_STEP wraps modulo 2^XLEN with no flag.
- Latency:
  - Zero-wait memory gives one instruction per cycle.
  - Redirect to first valid instruction from the new target is 2 cycles with zero-wait memory.
  - With a busy memory, redirect latency is (remaining busy cycles) + 2.

Test Plan:
- Reset then run, RESET_VECTOR=0, zero-wait memory returning addr-derived words → IFID_PC sequence 0,4,8,12 on consecutive cycles; IFID_VALID=1 from 2nd cycle; IFID_PC_NEXT=IFID_PC+4.
- STALL=1 for 3 cycles while IFID_PC=8 → PC stays 12 and IFID_PC/IFID_INSTR hold; after release IFID_PC=12 next cycle with no skipped or duplicated instruction.
- REDIRECT=1 with target 0x100 while memory ready → IFID_VALID=0 next cycle; following cycle IFID_PC=0x100.
- Memory busy 4 cycles; REDIRECT to 0x200 in busy cycle 1, then REDIRECT to 0x300 in busy cycle 3 → IMEM_ADDR unchanged until done; no valid IF/ID during drain; PC=0x300 after done; first valid IFID_PC=0x300.
- REDIRECT with target 0x102 → ADDR_MISALIGNED high exactly one cycle; PC=0x100. Separately, PC=0xFFFFFFFC with sequential fetch → PC wraps to 0.
- RESET asserted during DRAIN → next cycle PC=RESET_VECTOR, state RUN, IFID_VALID=0; stale memory response ignored.

Source files
------------

// File: rtl/pc_fetch_stage_if.sv
// pc_fetch_stage_if
//   Bundles every non-clock/reset signal of the fetch stage.
//   master : the fetch stage (drives the imem request and the IF/ID outputs)
//   slave  : the surrounding CPU/memory (drives control and imem response)
//   Signals:
//     stall            hazard unit: hold PC and IF/ID
//     redirect         EX stage: branch taken / jump
//     redirect_target  redirect destination address
//     imem_busywait    instruction memory not ready
//     imem_instr       instruction data from memory
//     imem_read        fetch request
//     imem_addr        fetch address (= pc)
//     pc               current fetch PC
//     ifid_pc          PC of the instruction held in IF/ID
//     ifid_pc_next     ifid_pc + PC_STEP (link value)
//     ifid_instr       instruction held in IF/ID
//     ifid_valid       IF/ID holds a live instruction (0 = bubble)
//     addr_misaligned  one-cycle pulse: accepted redirect target misaligned
interface pc_fetch_stage_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            imem_busywait;
  logic [ILEN-1:0] imem_instr;
  logic            imem_read;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ifid_pc;
  logic [XLEN-1:0] ifid_pc_next;
  logic [ILEN-1:0] ifid_instr;
  logic            ifid_valid;
  logic            addr_misaligned;

  modport master (
    input  stall, redirect, redirect_target, imem_busywait, imem_instr,
    output imem_read, imem_addr, pc, ifid_pc, ifid_pc_next, ifid_instr,
           ifid_valid, addr_misaligned
  );

  modport slave (
    output stall, redirect, redirect_target, imem_busywait, imem_instr,
    input  imem_read, imem_addr, pc, ifid_pc, ifid_pc_next, ifid_instr,
           ifid_valid, addr_misaligned
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage
//   Program counter and instruction-fetch stage of the pipelined RV32 CPU.
//   Owns the PC, issues busywait-style instruction-memory reads and loads
//   the IF/ID pipeline register. Handles hazard stalls and EX redirects,
//   including a redirect that arrives while a fetch is still in flight
//   (the stale access is drained before the new target is fetched).
//   Ports:
//     clk_i  clock, rising edge
//     rst_i  synchronous active-high reset
//     bus    pc_fetch_stage_if.master (control, imem handshake, IF/ID outputs)
//   PC_STEP must be a power of two.
module pc_fetch_stage #(
  parameter int          XLEN         = 32,
  parameter int          ILEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int          PC_STEP      = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  pc_fetch_stage_if.master bus
);

  typedef enum logic {RUN, DRAIN} state_t;

  localparam logic [XLEN-1:0] STEP  = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] LOW_M = XLEN'(PC_STEP - 1);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pending_q, pending_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_pc_next_q, ifid_pc_next_d;
  logic [ILEN-1:0] ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            misaligned_q, misaligned_d;

  logic            imem_read;
  logic            done;
  logic [XLEN-1:0] target_aligned;
  logic            target_low_nz;

  // Request is held high continuously; only reset withdraws it.
  assign imem_read      = ~rst_i;
  assign done           = imem_read & ~bus.imem_busywait;
  assign target_aligned = bus.redirect_target & ~LOW_M;
  assign target_low_nz  = |(bus.redirect_target & LOW_M);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pending_d      = pending_q;
    ifid_pc_d      = ifid_pc_q;
    ifid_pc_next_d = ifid_pc_next_q;
    ifid_instr_d   = ifid_instr_q;
    ifid_valid_d   = ifid_valid_q;
    misaligned_d   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.redirect) begin
          // Redirect beats stall: the ID instruction is flushed anyway.
          ifid_valid_d = 1'b0;
          misaligned_d = target_low_nz;
          if (done) begin
            pc_d = target_aligned;
          end else begin
            // Address must stay stable until the outstanding access ends.
            pending_d = target_aligned;
            state_d   = DRAIN;
          end
        end else if (bus.stall) begin
          // Hold everything; a returned word is dropped and refetched later.
        end else if (done) begin
          ifid_pc_d      = pc_q;
          ifid_pc_next_d = pc_q + STEP;
          ifid_instr_d   = bus.imem_instr;
          ifid_valid_d   = 1'b1;
          pc_d           = pc_q + STEP;
        end else begin
          // Memory busy: present a bubble rather than a duplicate.
          ifid_valid_d = 1'b0;
        end
      end

      DRAIN: begin
        ifid_valid_d = 1'b0;
        if (bus.redirect) begin
          pending_d    = target_aligned;
          misaligned_d = target_low_nz;
        end
        if (done) begin
          // Newest redirect wins even when it lands on the completing cycle.
          pc_d    = bus.redirect ? target_aligned : pending_q;
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= RUN;
      pc_q           <= XLEN'(RESET_VECTOR);
      pending_q      <= '0;
      ifid_pc_q      <= '0;
      ifid_pc_next_q <= '0;
      ifid_instr_q   <= '0;
      ifid_valid_q   <= 1'b0;
      misaligned_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pending_q      <= pending_d;
      ifid_pc_q      <= ifid_pc_d;
      ifid_pc_next_q <= ifid_pc_next_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_valid_q   <= ifid_valid_d;
      misaligned_q   <= misaligned_d;
    end
  end

  assign bus.imem_read       = imem_read;
  assign bus.imem_addr       = pc_q;
  assign bus.pc              = pc_q;
  assign bus.ifid_pc         = ifid_pc_q;
  assign bus.ifid_pc_next    = ifid_pc_next_q;
  assign bus.ifid_instr      = ifid_instr_q;
  assign bus.ifid_valid      = ifid_valid_q;
  assign bus.addr_misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
module tb_pc_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  pc_fetch_stage_if #(.XLEN(32), .ILEN(32)) bus ();

  // Memory model: returned word is the bitwise inverse of the address.
  assign bus.imem_instr = ~bus.imem_addr;

  pc_fetch_stage #(
    .XLEN(32), .ILEN(32), .RESET_VECTOR(32'h0), .PC_STEP(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = '0;
    bus.imem_busywait = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 32'h0000_0702;
    tick();
    n_checks++; if (bus.pc !== 32'h0) begin n_fails++; $display("FAIL reset_pc: got %h expected %h", bus.pc, 32'h0); end
    n_checks++; if (bus.ifid_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b expected 0", bus.ifid_valid); end
    n_checks++; if (bus.ifid_pc !== 32'h0) begin n_fails++; $display("FAIL reset_ifid_pc: got %h expected 0", bus.ifid_pc); end
    n_checks++; if (bus.ifid_pc_next !== 32'h0) begin n_fails++; $display("FAIL reset_ifid_pc_next: got %h expected 0", bus.ifid_pc_next); end
    n_checks++; if (bus.ifid_instr !== 32'h0) begin n_fails++; $display("FAIL reset_ifid_instr: got %h expected 0", bus.ifid_instr); end
    n_checks++; if (bus.addr_misaligned !== 1'b0) begin n_fails++; $display("FAIL reset_misaligned: got %b expected 0", bus.addr_misaligned); end
    n_checks++; if (bus.imem_read !== 1'b0) begin n_fails++; $display("FAIL reset_imem_read: got %b expected 0", bus.imem_read); end
    rst = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = '0;
    #1;
    n_checks++; if (bus.imem_read !== 1'b1) begin n_fails++; $display("FAIL run_imem_read: got %b expected 1", bus.imem_read); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_pc = 32'(4 * k);
      tick();
      n_checks++; if (bus.ifid_pc !== exp_pc) begin n_fails++; $display("FAIL seq_ifid_pc[%0d]: got %h expected %h", k, bus.ifid_pc, exp_pc); end
      n_checks++; if (bus.ifid_pc_next !== exp_pc + 32'd4) begin n_fails++; $display("FAIL seq_ifid_pc_next[%0d]: got %h expected %h", k, bus.ifid_pc_next, exp_pc + 32'd4); end
      n_checks++; if (bus.ifid_instr !== ~exp_pc) begin n_fails++; $display("FAIL seq_ifid_instr[%0d]: got %h expected %h", k, bus.ifid_instr, ~exp_pc); end
      n_checks++; if (bus.ifid_valid !== 1'b1) begin n_fails++; $display("FAIL seq_valid[%0d]: got %b expected 1", k, bus.ifid_valid); end
      n_checks++; if (bus.imem_addr !== exp_pc + 32'd4) begin n_fails++; $display("FAIL seq_imem_addr[%0d]: got %h expected %h", k, bus.imem_addr, exp_pc + 32'd4); end
      $display("seq fetch %0d: ifid_pc=%h instr=%h", k, bus.ifid_pc, bus.ifid_instr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick(); tick();
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (bus.pc !== 32'd12) begin n_fails++; $display("FAIL stall_pc[%0d]: got %h expected %h", k, bus.pc, 32'd12); end
      n_checks++; if (bus.ifid_pc !== 32'd8) begin n_fails++; $display("FAIL stall_ifid_pc[%0d]: got %h expected %h", k, bus.ifid_pc, 32'd8); end
      n_checks++; if (bus.ifid_instr !== ~32'd8) begin n_fails++; $display("FAIL stall_ifid_instr[%0d]: got %h expected %h", k, bus.ifid_instr, ~32'd8); end
      n_checks++; if (bus.ifid_valid !== 1'b1) begin n_fails++; $display("FAIL stall_valid[%0d]: got %b expected 1", k, bus.ifid_valid); end
    end
    bus.stall = 1'b0;
    tick();
    n_checks++; if (bus.ifid_pc !== 32'd12) begin n_fails++; $display("FAIL unstall_ifid_pc: got %h expected %h", bus.ifid_pc, 32'd12); end
    n_checks++; if (bus.ifid_instr !== ~32'd12) begin n_fails++; $display("FAIL unstall_ifid_instr: got %h expected %h", bus.ifid_instr, ~32'd12); end
    tick();
    n_checks++; if (bus.ifid_pc !== 32'd16) begin n_fails++; $display("FAIL unstall_ifid_pc2: got %h expected %h", bus.ifid_pc, 32'd16); end
    $display("test_stall done: ifid_pc=%h", bus.ifid_pc);
  endtask

  task automatic test_busy_bubble();
    do_reset();
    tick();
    bus.imem_busywait = 1'b1;
    tick();
    n_checks++; if (bus.ifid_valid !== 1'b0) begin n_fails++; $display("FAIL bubble_valid: got %b expected 0", bus.ifid_valid); end
    n_checks++; if (bus.pc !== 32'd4) begin n_fails++; $display("FAIL bubble_pc: got %h expected %h", bus.pc, 32'd4); end
    bus.imem_busywait = 1'b0;
    tick();
    n_checks++; if (bus.ifid_pc !== 32'd4 || bus.ifid_valid !== 1'b1) begin n_fails++; $display("FAIL bubble_resume: got pc=%h v=%b expected pc=%h v=1", bus.ifid_pc, bus.ifid_valid, 32'd4); end
    $display("test_busy_bubble done");
  endtask

  task automatic test_redirect();
    do_reset();
    tick();
    bus.redirect = 1'b1; bus.redirect_target = 32'h100;
    bus.stall = 1'b1;
    tick();
    n_checks++; if (bus.ifid_valid !== 1'b0) begin n_fails++; $display("FAIL redir_valid: got %b expected 0", bus.ifid_valid); end
    n_checks++; if (bus.pc !== 32'h100) begin n_fails++; $display("FAIL redir_pc: got %h expected %h", bus.pc, 32'h100); end
    n_checks++; if (bus.addr_misaligned !== 1'b0) begin n_fails++; $display("FAIL redir_misaligned: got %b expected 0", bus.addr_misaligned); end
    bus.redirect = 1'b0; bus.stall = 1'b0;
    tick();
    n_checks++; if (bus.ifid_pc !== 32'h100) begin n_fails++; $display("FAIL redir_ifid_pc: got %h expected %h", bus.ifid_pc, 32'h100); end
    n_checks++; if (bus.ifid_pc_next !== 32'h104) begin n_fails++; $display("FAIL redir_ifid_pc_next: got %h expected %h", bus.ifid_pc_next, 32'h104); end
    n_checks++; if (bus.ifid_valid !== 1'b1) begin n_fails++; $display("FAIL redir_valid2: got %b expected 1", bus.ifid_valid); end
    $display("test_redirect done: ifid_pc=%h", bus.ifid_pc);
  endtask

  task automatic test_drain();
    do_reset();
    tick();
    bus.imem_busywait = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      bus.redirect = (c == 1 || c == 3);
      bus.redirect_target = (c == 1) ? 32'h200 : 32'h300;
      tick();
      n_checks++; if (bus.imem_addr !== 32'd4) begin n_fails++; $display("FAIL drain_addr[%0d]: got %h expected %h", c, bus.imem_addr, 32'd4); end
      n_checks++; if (bus.ifid_valid !== 1'b0) begin n_fails++; $display("FAIL drain_valid[%0d]: got %b expected 0", c, bus.ifid_valid); end
    end
    bus.redirect = 1'b0; bus.imem_busywait = 1'b0;
    tick();
    n_checks++; if (bus.pc !== 32'h300) begin n_fails++; $display("FAIL drain_pc: got %h expected %h", bus.pc, 32'h300); end
    n_checks++; if (bus.ifid_valid !== 1'b0) begin n_fails++; $display("FAIL drain_done_valid: got %b expected 0", bus.ifid_valid); end
    tick();
    n_checks++; if (bus.ifid_pc !== 32'h300 || bus.ifid_valid !== 1'b1) begin n_fails++; $display("FAIL drain_first: got pc=%h v=%b expected pc=%h v=1", bus.ifid_pc, bus.ifid_valid, 32'h300); end
    $display("test_drain done: ifid_pc=%h", bus.ifid_pc);
  endtask

  task automatic test_misaligned_wrap();
    do_reset();
    tick();
    bus.redirect = 1'b1; bus.redirect_target = 32'h102;
    tick();
    n_checks++; if (bus.addr_misaligned !== 1'b1) begin n_fails++; $display("FAIL misal_pulse: got %b expected 1", bus.addr_misaligned); end
    n_checks++; if (bus.pc !== 32'h100) begin n_fails++; $display("FAIL misal_pc: got %h expected %h", bus.pc, 32'h100); end
    bus.redirect = 1'b0;
    tick();
    n_checks++; if (bus.addr_misaligned !== 1'b0) begin n_fails++; $display("FAIL misal_clear: got %b expected 0", bus.addr_misaligned); end
    n_checks++; if (bus.ifid_pc !== 32'h100) begin n_fails++; $display("FAIL misal_ifid_pc: got %h expected %h", bus.ifid_pc, 32'h100); end
    bus.redirect = 1'b1; bus.redirect_target = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    n_checks++; if (bus.pc !== 32'hFFFF_FFFC) begin n_fails++; $display("FAIL wrap_pc_top: got %h expected %h", bus.pc, 32'hFFFF_FFFC); end
    tick();
    n_checks++; if (bus.pc !== 32'h0) begin n_fails++; $display("FAIL wrap_pc: got %h expected 0", bus.pc); end
    n_checks++; if (bus.ifid_pc_next !== 32'h0) begin n_fails++; $display("FAIL wrap_pc_next: got %h expected 0", bus.ifid_pc_next); end
    n_checks++; if (bus.ifid_pc !== 32'hFFFF_FFFC) begin n_fails++; $display("FAIL wrap_ifid_pc: got %h expected %h", bus.ifid_pc, 32'hFFFF_FFFC); end
    $display("test_misaligned_wrap done: pc=%h", bus.pc);
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    tick();
    bus.imem_busywait = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 32'h400;
    tick();
    bus.redirect = 1'b0; bus.imem_busywait = 1'b0; rst = 1'b1;
    tick();
    n_checks++; if (bus.pc !== 32'h0) begin n_fails++; $display("FAIL rstdrain_pc: got %h expected 0", bus.pc); end
    n_checks++; if (bus.ifid_valid !== 1'b0) begin n_fails++; $display("FAIL rstdrain_valid: got %b expected 0", bus.ifid_valid); end
    rst = 1'b0;
    tick();
    // In RUN the fetch from 0 completes; a lingering DRAIN would jump to 0x400.
    n_checks++; if (bus.pc !== 32'd4 || bus.ifid_pc !== 32'h0 || bus.ifid_valid !== 1'b1) begin n_fails++; $display("FAIL rstdrain_run: got pc=%h ifid_pc=%h v=%b expected pc=%h ifid_pc=0 v=1", bus.pc, bus.ifid_pc, bus.ifid_valid, 32'd4); end
    $display("test_reset_in_drain done: pc=%h", bus.pc);
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = '0;
    bus.imem_busywait = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_busy_bubble();
    test_redirect();
    test_drain();
    test_misaligned_wrap();
    test_reset_in_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
